// File: rtl/counter_range.sv
// Bounded up/down counter over [min(A,B), max(A,B)] with wrap or ping-pong behaviour.
// Define COUNTER_RANGE_BOUNCE_EN to build the bounce (ping-pong) mode; otherwise MODE is ignored.
module counter_range #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic             EN,
  input  logic             D,
  input  logic             MODE,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic             Z_carry,
  output logic             DIR
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             z_q, z_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] lo, hi;
  logic             dir_eff;

  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v,
                                             input logic [WIDTH-1:0] l,
                                             input logic [WIDTH-1:0] h);
    if (v < l)      return l;
    else if (v > h) return h;
    else            return v;
  endfunction

`ifdef COUNTER_RANGE_BOUNCE_EN
  assign dir_eff = MODE ? dir_q : D;
`else
  logic unused_mode;
  assign unused_mode = MODE;
  assign dir_eff     = D;
`endif

  always_comb begin
    lo    = (A < B) ? A : B;
    hi    = (A < B) ? B : A;
    cnt_d = cnt_q;
    dir_d = dir_q;
    z_d   = 1'b0;
    if (LOAD) begin
      cnt_d = clamp(LOAD_VAL, lo, hi);
      dir_d = D;
    end else if (EN) begin
      dir_d = dir_eff;
      if ((cnt_q < lo) || (cnt_q > hi)) begin
        // Re-enter the range from the side we are heading toward
        cnt_d = dir_eff ? hi : lo;
      end else if (lo == hi) begin
        cnt_d = lo;
        z_d   = 1'b1;
      end
`ifdef COUNTER_RANGE_BOUNCE_EN
      else if (MODE) begin
        if (!dir_q) begin
          if (cnt_q == hi) begin
            cnt_d = cnt_q - WIDTH'(1);
            dir_d = 1'b1;
            z_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end else begin
          if (cnt_q == lo) begin
            cnt_d = cnt_q + WIDTH'(1);
            dir_d = 1'b0;
            z_d   = 1'b1;
          end else begin
            cnt_d = cnt_q - WIDTH'(1);
          end
        end
      end
`endif
      else begin
        if (!D) begin
          if (cnt_q == hi) begin
            cnt_d = lo;
            z_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end else begin
          if (cnt_q == lo) begin
            cnt_d = hi;
            z_d   = 1'b1;
          end else begin
            cnt_d = cnt_q - WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      cnt_q <= '0;
      z_q   <= 1'b0;
      dir_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      z_q   <= z_d;
      dir_q <= dir_d;
    end
  end

  assign Q       = cnt_q;
  assign Z_carry = z_q;
  assign DIR     = dir_q;

endmodule

// File: tb/tb_counter_range.sv
// Scoreboard bench for counter_range (WIDTH=4); covers wrap, load clamping, degenerate range and bounce/no-bounce builds.
module tb_counter_range;

  localparam int W = 4;

  logic         clk;
  logic         reset_p;
  logic         EN, D, MODE, LOAD;
  logic [W-1:0] LOAD_VAL, A, B;
  logic [W-1:0] Q;
  logic         Z_carry, DIR;

  typedef struct {
    string        tag;
    logic [W-1:0] q;
    logic         z;
    logic         dir;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  counter_range #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset_p  (reset_p),
    .EN       (EN),
    .D        (D),
    .MODE     (MODE),
    .LOAD     (LOAD),
    .LOAD_VAL (LOAD_VAL),
    .A        (A),
    .B        (B),
    .Q        (Q),
    .Z_carry  (Z_carry),
    .DIR      (DIR)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected result, then pop and compare after the edge.
  task automatic step(input logic en, input logic d, input logic mode, input logic ld,
                      input logic [W-1:0] lv, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] eq, input logic ez, input logic edir, input string tag);
    exp_t e;
    EN = en; D = d; MODE = mode; LOAD = ld; LOAD_VAL = lv; A = a; B = b;
    e.tag = tag; e.q = eq; e.z = ez; e.dir = edir;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".q"}, 32'(Q), 32'(e.q));
      chk({e.tag, ".z"}, 32'(Z_carry), 32'(e.z));
      chk({e.tag, ".dir"}, 32'(DIR), 32'(e.dir));
    end
  endtask

  // Assert reset between edges, verify it acts without a clock, hold it, release away from an edge.
  task automatic async_reset(input string tag, input int hold_ns);
    #2;
    reset_p = 1'b1;
    #1;
    chk({tag, ".q"}, 32'(Q), 32'd0);
    chk({tag, ".z"}, 32'(Z_carry), 32'd0);
    chk({tag, ".dir"}, 32'(DIR), 32'd0);
    #(hold_ns);
    chk({tag, "_hold.q"}, 32'(Q), 32'd0);
    @(posedge clk);
    #1;
    reset_p = 1'b0;
  endtask

  initial begin
    reset_p = 1'b1;
    EN = 1'b0; D = 1'b0; MODE = 1'b0; LOAD = 1'b0;
    LOAD_VAL = '0; A = '0; B = '0;
    #2;
    chk("rst_init.q", 32'(Q), 32'd0);
    chk("rst_init.z", 32'(Z_carry), 32'd0);
    chk("rst_init.dir", 32'(DIR), 32'd0);
    @(posedge clk);
    #1;
    reset_p = 1'b0;

    // Wrap up through 4..13 from Q=0
    step(1, 0, 0, 0, 0, 4, 13, 4, 0, 0, "wrap_entry");
    for (int i = 5; i <= 13; i++) step(1, 0, 0, 0, 0, 4, 13, W'(i), 0, 0, "wrap_up");
    step(1, 0, 0, 0, 0, 4, 13, 4, 1, 0, "wrap_hi_to_lo");
    step(1, 0, 0, 0, 0, 4, 13, 5, 0, 0, "wrap_after");
    step(1, 0, 0, 0, 0, 4, 13, 6, 0, 0, "wrap_mid");

    async_reset("rst_mid", 200);
    step(1, 0, 0, 0, 0, 4, 13, 4, 0, 0, "post_rst");
    step(1, 0, 0, 0, 0, 4, 13, 5, 0, 0, "post_rst2");

    // Swapped bounds, counting down through the wrap
    step(0, 1, 0, 1, 6, 13, 4, 6, 0, 1, "load6");
    step(1, 1, 0, 0, 0, 13, 4, 5, 0, 1, "down5");
    step(1, 1, 0, 0, 0, 13, 4, 4, 0, 1, "down4");
    step(1, 1, 0, 0, 0, 13, 4, 13, 1, 1, "down_wrap");
    step(1, 1, 0, 0, 0, 13, 4, 12, 0, 1, "down12");
    step(1, 1, 0, 0, 0, 13, 4, 11, 0, 1, "down11");

    // Load priority over EN and clamping
    step(1, 0, 0, 1, 15, 4, 13, 13, 0, 0, "load_clamp_hi");
    step(1, 0, 0, 1, 1, 4, 13, 4, 0, 0, "load_clamp_lo");
    step(1, 1, 0, 1, 7, 4, 13, 7, 0, 1, "load_in_range");
    step(0, 0, 0, 0, 0, 4, 13, 7, 0, 1, "hold_en0");
    step(0, 1, 0, 1, 4, 4, 13, 4, 0, 1, "load4");
    step(1, 1, 0, 0, 0, 4, 13, 13, 1, 1, "down_wrap2");
    step(1, 0, 0, 1, 15, 4, 13, 13, 0, 0, "load_after_wrap");
    step(1, 0, 0, 0, 0, 4, 13, 4, 1, 0, "wrap_from_load");
    step(0, 1, 0, 0, 0, 4, 13, 4, 0, 0, "en0_clr_z");
    step(0, 1, 0, 0, 0, 4, 13, 4, 0, 0, "en0_hold");

    // Degenerate range A==B
    async_reset("rst_deg", 30);
    step(1, 0, 0, 0, 0, 9, 9, 9, 0, 0, "deg_entry");
    step(1, 0, 0, 0, 0, 9, 9, 9, 1, 0, "deg_hold1");
    step(1, 0, 0, 0, 0, 9, 9, 9, 1, 0, "deg_hold2");
    step(0, 0, 0, 0, 0, 9, 9, 9, 0, 0, "deg_en0");

    // Bound change leaves Q out of range; re-enter from hi when going down
    step(1, 1, 0, 0, 0, 2, 5, 5, 0, 1, "bound_chg");
    step(1, 1, 0, 0, 0, 2, 5, 4, 0, 1, "bound_chg_dn");

`ifdef COUNTER_RANGE_BOUNCE_EN
    step(0, 0, 1, 1, 4, 4, 7, 4, 0, 0, "bnc_load");
    step(1, 1, 1, 0, 0, 4, 7, 5, 0, 0, "bnc_up5");
    step(1, 1, 1, 0, 0, 4, 7, 6, 0, 0, "bnc_up6");
    step(1, 0, 1, 0, 0, 4, 7, 7, 0, 0, "bnc_up7");
    step(1, 0, 1, 0, 0, 4, 7, 6, 1, 1, "bnc_turn_hi");
    step(1, 0, 1, 0, 0, 4, 7, 5, 0, 1, "bnc_dn5");
    step(1, 0, 1, 0, 0, 4, 7, 4, 0, 1, "bnc_dn4");
    step(1, 1, 1, 0, 0, 4, 7, 5, 1, 0, "bnc_turn_lo");
    step(1, 1, 1, 0, 0, 4, 7, 6, 0, 0, "bnc_up6b");
    step(1, 1, 1, 0, 0, 6, 6, 6, 1, 0, "bnc_deg");
    step(1, 0, 0, 0, 0, 4, 7, 7, 0, 0, "mode_to_wrap");
    step(1, 0, 0, 0, 0, 4, 7, 4, 1, 0, "mode_wrap_hi");
`else
    step(0, 0, 1, 1, 4, 4, 7, 4, 0, 0, "nob_load");
    step(1, 0, 1, 0, 0, 4, 7, 5, 0, 0, "nob_up5");
    step(1, 0, 1, 0, 0, 4, 7, 6, 0, 0, "nob_up6");
    step(1, 0, 1, 0, 0, 4, 7, 7, 0, 0, "nob_up7");
    step(1, 0, 1, 0, 0, 4, 7, 4, 1, 0, "nob_wrap");
    step(1, 0, 1, 0, 0, 4, 7, 5, 0, 0, "nob_after");
    step(1, 1, 1, 0, 0, 4, 7, 4, 0, 1, "nob_down4");
    step(1, 1, 1, 0, 0, 4, 7, 7, 1, 1, "nob_dwrap");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
